// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and Gray-pointer helpers for the async FIFO controllers
package fifo_pkg;

    localparam int DEF_ADDR_W = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray code of a pointer exactly one lap ahead of g: invert its top two bits
    function automatic logic [31:0] full_gray(input logic [31:0] g, input int aw);
        return g ^ (32'd3 << (aw - 1));
    endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary conversion (prefix XOR from the MSB down)
//   gray : Gray-coded input
//   bin  : binary equivalent
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-domain controller (pointers, full/almost-full, fill level, overflow)
//   clk, rst         : write clock, asynchronous active-low reset
//   wr_en            : write request
//   rd_ptr_gray_sync : Gray read pointer already synchronized into clk domain
//   mem_we, wr_addr  : memory write port
//   wr_ptr_gray      : registered Gray write pointer for the read-domain synchronizer
//   full, almost_full, fill_level, overflow : registered status
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AFULL_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_ptr_gray_sync,
    output logic              mem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_LIM = PW'((1 << ADDR_W) - AFULL_TH);

    logic [PW-1:0] wr_ptr_bin;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] fill_next;

    // No memory write while reset is held, even with wr_en high
    assign mem_we    = wr_en & ~full & rst;
    assign wr_addr   = wr_ptr_bin[ADDR_W-1:0];
    assign bin_next  = wr_ptr_bin + PW'(mem_we);
    assign gray_next = PW'(bin2gray(32'(bin_next)));
    assign fill_next = bin_next - rd_bin;

    gray2bin #(.WIDTH(PW)) u_rd_g2b (
        .gray (rd_ptr_gray_sync),
        .bin  (rd_bin)
    );

    // Status is computed from the next write pointer and the current synced
    // read pointer, so an accept and a read-pointer move land in the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr_bin  <= bin_next;
            wr_ptr_gray <= gray_next;
            full        <= gray_next == PW'(full_gray(32'(rd_ptr_gray_sync), ADDR_W));
            almost_full <= fill_next >= AF_LIM;
            fill_level  <= fill_next;
            overflow    <= wr_en & full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: scoreboard bench for fifo_wr_ctrl using a write/read count model
module tb_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] rd_ptr_gray_sync = '0;
    logic       mem_we, full, almost_full, overflow;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray, fill_level;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       mem_we;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] fill;
        logic       ovf;
    } exp_t;

    exp_t q[$];

    // Model: total writes accepted and read-pointer position as plain counts
    int wcnt = 0;
    int cur_rc = 0;
    int fill = 0;
    bit cur_we = 1'b0;
    bit e_full = 1'b0;
    bit e_af = 1'b0;
    bit e_ovf = 1'b0;
    bit seen_top = 1'b0;
    bit seen_wrap = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(.ADDR_W(4), .AFULL_TH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .mem_we           (mem_we),
        .wr_addr          (wr_addr),
        .wr_ptr_gray      (wr_ptr_gray),
        .full             (full),
        .almost_full      (almost_full),
        .fill_level       (fill_level),
        .overflow         (overflow)
    );

    function automatic logic [4:0] g(input int n);
        int m;
        m = n % 32;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and update the model with the inputs of the cycle just ended
    task automatic tick();
        @(posedge clk);
        #1;
        e_ovf = cur_we && e_full;
        if (cur_we && !e_full) wcnt++;
        fill = wcnt - cur_rc;
        e_full = fill == 16;
        e_af = fill >= 14;
    endtask

    task automatic drive(input bit we, input int rc);
        cur_we = we;
        cur_rc = rc;
        wr_en = we;
        rd_ptr_gray_sync = g(rc);
        q.push_back('{we && !e_full, 4'(wcnt % 16), g(wcnt), e_full, e_af, 5'(fill), e_ovf});
    endtask

    task automatic model_reset();
        wcnt = 0;
        cur_rc = 0;
        fill = 0;
        e_full = 1'b0;
        e_af = 1'b0;
        e_ovf = 1'b0;
        rd_ptr_gray_sync = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gray"}, wr_ptr_gray, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_fill"}, fill_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_we"}, mem_we, 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_mem_we", mem_we, e.mem_we);
            chk("sb_wr_addr", wr_addr, e.addr);
            chk("sb_gray", wr_ptr_gray, e.gray);
            chk("sb_full", full, e.full);
            chk("sb_afull", almost_full, e.af);
            chk("sb_fill", fill_level, e.fill);
            chk("sb_ovf", overflow, e.ovf);
        end
    end

    initial begin
        #1 rst = 1'b0;
        wr_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        cur_we = 1'b1;
        #1;
        chk("release_we", mem_we, 1);
        chk("release_addr", wr_addr, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 13) chk("af_at13", almost_full, 0);
            if (i == 14) chk("af_at14", almost_full, 1);
            drive(1'b1, 0);
        end
        tick();
        chk("fill_full", full, 1);
        chk("fill_level16", fill_level, 16);
        chk("fill_gray", wr_ptr_gray, 5'b11000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0);
            #1 chk("ovf_we", mem_we, 0);
            tick();
            chk("ovf_pulse", overflow, 1);
            chk("ovf_gray_hold", wr_ptr_gray, 5'b11000);
        end
        drive(1'b0, 4);
        tick();
        chk("drain_full", full, 0);
        chk("drain_fill", fill_level, 12);
        chk("drain_af", almost_full, 0);
        chk("drain_ovf", overflow, 0);
        drive(1'b0, 13);
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, wcnt - 2);
            tick();
            chk("wrap_fill", fill_level, 3);
            chk("wrap_full", full, 0);
            if (wr_ptr_gray == 5'b10000) seen_top = 1'b1;
            if (seen_top && wr_ptr_gray == 5'b00000) seen_wrap = 1'b1;
        end
        chk("wrap_seen", seen_wrap, 1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, wcnt - 2);
            tick();
        end
        drive(1'b1, wcnt - 2);
        #2 rst = 1'b0;
        q.delete();
        model_reset();
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("resume_addr", wr_addr, 0);
        chk("resume_we", mem_we, 1);
        for (int i = 0; i < 400; i++) begin
            int rc;
            int step;
            tick();
            rc = cur_rc;
            if ($urandom_range(0, 99) < (i < 200 ? 15 : 60) && rc < wcnt) begin
                step = wcnt - rc > 3 ? 3 : wcnt - rc;
                rc += int'($urandom_range(1, step));
            end
            drive($urandom_range(0, 3) != 0, rc);
        end
        tick();
        drive(1'b0, cur_rc);
        @(negedge clk);
        #1 chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
